// File: rtl/sync_filter_bank.sv
// Multi-channel bit synchronizer with per-channel glitch filter and edge pulses.
// Optional multi-bit-change check on the synchronized bus: SYNC_FILTER_GRAY_CHECK_EN.
module sync_filter_bank #(
  parameter int             WIDTH      = 8,
  parameter int             STAGES     = 2,
  parameter int             FILTER_CNT = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             gray_err
);

  localparam int CNT_W = $clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILTER_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);

  logic [WIDTH-1:0] sync_p [STAGES];
  logic [WIDTH-1:0] synced;
  logic [CNT_W-1:0] cnt    [WIDTH];
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] upd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Stage boundary: asynchronous din into the flip-flop chain (always runs, ignores en)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) sync_p[s] <= RST_VAL;
    end else begin
      sync_p[0] <= din;
      for (int s = 1; s < STAGES; s++) sync_p[s] <= sync_p[s-1];
    end
  end

  assign synced = sync_p[STAGES-1];

  always_comb begin
    mismatch = synced ^ dout;
    upd      = '0;
    for (int i = 0; i < WIDTH; i++)
      upd[i] = en && mismatch[i] && (cnt[i] >= CNT_LAST);
  end

  // Stage boundary: filter counters, filtered level and edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      dout    <= RST_VAL;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      rise    <= upd & synced;
      fall    <= upd & ~synced;
      changed <= |upd;
      if (en) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (upd[i]) begin
            dout[i] <= synced[i];
            cnt[i]  <= '0;
          end else if (mismatch[i]) begin
            cnt[i]  <= sat_inc(cnt[i]);
          end else begin
            cnt[i]  <= '0;
          end
        end
      end
    end
  end

`ifdef SYNC_FILTER_GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_p;

  function automatic logic multi_bit(input logic [WIDTH-1:0] x);
    return (x & (x - WIDTH'(1))) != '0;
  endfunction

  // Stage boundary: previous synced sample and multi-bit-change flag
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p   <= RST_VAL;
      gray_err <= 1'b0;
    end else if (en) begin
      prev_p   <= synced;
      gray_err <= multi_bit(synced ^ prev_p);
    end else begin
      gray_err <= 1'b0;
    end
  end
`else
  assign gray_err = 1'b0;
`endif

endmodule
